// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM encoding,
// default NOP word and the sequential PC step.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Sequential successor of a PC; wraps modulo 2^32 by construction.
    function automatic logic [31:0] pc_plus_step(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: valid bit, instruction word and PC+4.
// Flush wins over load; with neither asserted the contents hold.
module pc_fetch_unit_if_id_reg
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;

    // Load / hold / flush of the IF/ID contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= NOP_WORD;
            r_pc4   <= 32'h0000_0000;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_WORD;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch unit: owns the PC, issues instruction-memory requests
// and fills the IF/ID register. A skid buffer parks a word that returns
// while ID is stalled; a redirect register remembers a taken branch that
// arrives while a request is still outstanding.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inPCSrc,
    input  logic [31:0] inBranchTarget,
    input  logic        inStall,
    output logic        outImemReq,
    output logic [31:0] outImemAddr,
    input  logic        inImemReady,
    input  logic [31:0] inImemData,
    output logic [31:0] outPC,
    output logic [31:0] outIFIDInstr,
    output logic [31:0] outIFIDPCPlus4,
    output logic        outIFIDValid
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc4;
    logic [31:0] r_redirect;

    logic [31:0] w_pc_plus4;
    logic        w_imem_req;
    logic        w_ifid_load;
    logic        w_ifid_flush;
    logic [31:0] w_ifid_instr;
    logic [31:0] w_ifid_pc4;
    logic        w_pc_load;
    logic [31:0] w_pc_next;
    logic        w_skid_load;
    logic        w_skid_clear;
    logic        w_redir_load;

    assign w_pc_plus4 = pc_plus_step(r_pc);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath controls; a taken branch outranks a stall everywhere
    always_comb begin
        w_state_nxt  = r_state;
        w_imem_req   = 1'b0;
        w_ifid_load  = 1'b0;
        w_ifid_flush = 1'b0;
        w_ifid_instr = inImemData;
        w_ifid_pc4   = w_pc_plus4;
        w_pc_load    = 1'b0;
        w_pc_next    = w_pc_plus4;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        w_redir_load = 1'b0;

        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_REQ;
            end

            ST_REQ: begin
                w_imem_req = 1'b1;
                if (inPCSrc) begin
                    w_ifid_flush = 1'b1;
                    if (inImemReady) begin
                        // Wrong-path word arrives with the redirect: drop it.
                        w_pc_load = 1'b1;
                        w_pc_next = inBranchTarget;
                    end else begin
                        // Request in flight: keep it stable, remember the target.
                        w_redir_load = 1'b1;
                        w_state_nxt  = ST_DRAIN;
                    end
                end else if (inImemReady) begin
                    if (inStall) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_ifid_load = 1'b1;
                        w_pc_load   = 1'b1;
                    end
                end else if (!inStall) begin
                    // ID consumes its word every unstalled cycle; no new word means a bubble.
                    w_ifid_flush = 1'b1;
                end
            end

            ST_HOLD: begin
                if (inPCSrc) begin
                    w_ifid_flush = 1'b1;
                    w_skid_clear = 1'b1;
                    w_pc_load    = 1'b1;
                    w_pc_next    = inBranchTarget;
                    w_state_nxt  = ST_REQ;
                end else if (!inStall) begin
                    w_ifid_load  = 1'b1;
                    w_ifid_instr = r_skid_instr;
                    w_ifid_pc4   = r_skid_pc4;
                    w_pc_load    = 1'b1;
                    w_skid_clear = 1'b1;
                    w_state_nxt  = ST_REQ;
                end
            end

            ST_DRAIN: begin
                w_imem_req = 1'b1;
                if (inPCSrc) begin
                    w_ifid_flush = 1'b1;
                    w_redir_load = 1'b1;
                end
                if (inImemReady) begin
                    // Stale word discarded; a same-cycle branch is the newest target.
                    w_pc_load   = 1'b1;
                    w_pc_next   = inPCSrc ? inBranchTarget : r_redirect;
                    w_state_nxt = ST_REQ;
                end
            end

            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // Program counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= PC_RESET;
        end else if (w_pc_load) begin
            r_pc <= w_pc_next;
        end
    end

    // Skid buffer for a word that returned while ID was stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_instr <= 32'h0000_0000;
            r_skid_pc4   <= 32'h0000_0000;
        end else if (w_skid_load) begin
            r_skid_instr <= inImemData;
            r_skid_pc4   <= w_pc_plus4;
        end else if (w_skid_clear) begin
            r_skid_instr <= 32'h0000_0000;
            r_skid_pc4   <= 32'h0000_0000;
        end
    end

    // Redirect target pending behind an outstanding request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect <= 32'h0000_0000;
        end else if (w_redir_load) begin
            r_redirect <= inBranchTarget;
        end
    end

    pc_fetch_unit_if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_ifid_load),
        .i_flush (w_ifid_flush),
        .i_instr (w_ifid_instr),
        .i_pc4   (w_ifid_pc4),
        .o_valid (outIFIDValid),
        .o_instr (outIFIDInstr),
        .o_pc4   (outIFIDPCPlus4)
    );

    assign outImemReq  = w_imem_req;
    assign outImemAddr = r_pc;
    assign outPC       = r_pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: a memory stub returns a word derived from the
// address; accepted fetches are queued and compared when IF/ID updates.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inPCSrc;
    logic [31:0] inBranchTarget;
    logic        inStall;
    logic        outImemReq;
    logic [31:0] outImemAddr;
    logic        inImemReady;
    logic [31:0] inImemData;
    logic [31:0] outPC;
    logic [31:0] outIFIDInstr;
    logic [31:0] outIFIDPCPlus4;
    logic        outIFIDValid;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .PC_RESET (32'h0000_0000),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inPCSrc        (inPCSrc),
        .inBranchTarget (inBranchTarget),
        .inStall        (inStall),
        .outImemReq     (outImemReq),
        .outImemAddr    (outImemAddr),
        .inImemReady    (inImemReady),
        .inImemData     (inImemData),
        .outPC          (outPC),
        .outIFIDInstr   (outIFIDInstr),
        .outIFIDPCPlus4 (outIFIDPCPlus4),
        .outIFIDValid   (outIFIDValid)
    );

    // Memory contents: upper half = address low bits, lower half = their inverse.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic sb_push(input logic [31:0] instr, input logic [31:0] pc4);
        exp_t e;
        e.instr = instr;
        e.pc4   = pc4;
        sb_q.push_back(e);
    endtask

    // One clock: drive at the falling edge, observe at the next falling edge.
    task automatic cycle(input logic rdy, input logic stl, input logic src, input logic [31:0] tgt);
        exp_t e;
        inImemReady    = rdy;
        inStall        = stl;
        inPCSrc        = src;
        inBranchTarget = tgt;
        inImemData     = rdy ? word_of(outImemAddr) : 32'hBAD0_BAD0;
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("sb_valid", 32'(outIFIDValid), 32'd1);
            check_val("sb_instr", outIFIDInstr, e.instr);
            check_val("sb_pc4",   outIFIDPCPlus4, e.pc4);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        inPCSrc        = 1'b0;
        inBranchTarget = 32'h0;
        inStall        = 1'b0;
        inImemReady    = 1'b0;
        inImemData     = 32'h0;
        repeat (2) @(negedge clk);

        check_val("rst_pc",    outPC, 32'h0);
        check_val("rst_req",   32'(outImemReq), 32'd0);
        check_val("rst_valid", 32'(outIFIDValid), 32'd0);
        check_val("rst_instr", outIFIDInstr, 32'h0);
        check_val("rst_pc4",   outIFIDPCPlus4, 32'h0);

        rst_n = 1'b1;
        check_val("boot_req", 32'(outImemReq), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_val("req_on",  32'(outImemReq), 32'd1);
        check_val("addr_0",  outImemAddr, 32'h0);

        // Back-to-back fetches
        sb_push(word_of(32'h0), 32'h4);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("addr_4", outImemAddr, 32'h4);
        sb_push(word_of(32'h4), 32'h8);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("addr_8", outImemAddr, 32'h8);

        // Word returns under stall at PC=8
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("hold_req",   32'(outImemReq), 32'd0);
        check_val("hold_pc",    outPC, 32'h8);
        check_val("hold_instr", outIFIDInstr, word_of(32'h4));
        check_val("hold_pc4",   outIFIDPCPlus4, 32'h8);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_val("hold2_pc4",  outIFIDPCPlus4, 32'h8);
        sb_push(word_of(32'h8), 32'hC);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_val("unhold_pc",  outPC, 32'hC);
        check_val("unhold_req", 32'(outImemReq), 32'd1);
        sb_push(word_of(32'hC), 32'h10);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("addr_10", outImemAddr, 32'h10);

        // Branch coincides with ready
        cycle(1'b1, 1'b0, 1'b1, 32'h40);
        check_val("br_valid", 32'(outIFIDValid), 32'd0);
        check_val("br_instr", outIFIDInstr, 32'h0);
        check_val("br_addr",  outImemAddr, 32'h40);
        sb_push(word_of(32'h40), 32'h44);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("addr_44", outImemAddr, 32'h44);
        cycle(1'b1, 1'b0, 1'b1, 32'h14);
        check_val("addr_14", outImemAddr, 32'h14);

        // Branch while request outstanding, 3-cycle memory
        cycle(1'b0, 1'b0, 1'b1, 32'h80);
        check_val("drain_req",   32'(outImemReq), 32'd1);
        check_val("drain_addr",  outImemAddr, 32'h14);
        check_val("drain_valid", 32'(outIFIDValid), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_val("drain_addr2", outImemAddr, 32'h14);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_val("drain_addr3", outImemAddr, 32'h14);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("drain_done",  outImemAddr, 32'h80);
        check_val("drain_drop",  32'(outIFIDValid), 32'd0);

        // Second branch during drain overwrites the pending target
        cycle(1'b0, 1'b0, 1'b1, 32'h100);
        check_val("ovr_addr1", outImemAddr, 32'h80);
        cycle(1'b0, 1'b0, 1'b1, 32'h200);
        check_val("ovr_addr2", outImemAddr, 32'h80);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("ovr_target", outImemAddr, 32'h200);

        // Branch and stall together while holding a skid word
        sb_push(word_of(32'h200), 32'h204);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("addr_204", outImemAddr, 32'h204);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_val("hold2_req", 32'(outImemReq), 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 32'h300);
        check_val("hbr_valid", 32'(outIFIDValid), 32'd0);
        check_val("hbr_pc",    outPC, 32'h300);
        check_val("hbr_req",   32'(outImemReq), 32'd1);
        sb_push(word_of(32'h300), 32'h304);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("addr_304", outImemAddr, 32'h304);

        // PC wrap at the top of the address space
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check_val("addr_top", outImemAddr, 32'hFFFF_FFFC);
        sb_push(word_of(32'hFFFF_FFFC), 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("wrap_pc", outPC, 32'h0);
        sb_push(word_of(32'h0), 32'h4);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_val("wrap_addr4", outImemAddr, 32'h4);

        // Stall with nothing returned changes nothing
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_val("idle_addr",  outImemAddr, 32'h4);
        check_val("idle_req",   32'(outImemReq), 32'd1);
        check_val("idle_valid", 32'(outIFIDValid), 32'd1);
        check_val("idle_pc4",   outIFIDPCPlus4, 32'h4);

        // Asynchronous reset in the middle of a request
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_pc",    outPC, 32'h0);
        check_val("arst_req",   32'(outImemReq), 32'd0);
        check_val("arst_valid", 32'(outIFIDValid), 32'd0);

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, instruction word driven into IF/ID on flush or reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 inPCSrc  input  1  taken-branch redirect from the ID-stage branch resolver (BEQ/BNE outcome).
REQ-006 inBranchTarget  input  32  redirect target, valid when inPCSrc=1.
REQ-007 inStall  input  1  hazard-unit stall; IF/ID and PC hold.
REQ-008 outImemReq  output  1  instruction-memory request.
REQ-009 outImemAddr  output  32  fetch address, equals PC register.
REQ-010 inImemReady  input  1  memory returns data this cycle (completes request).
REQ-011 inImemData  input  32  instruction word, valid with inImemReady.
REQ-012 outPC  output  32  current PC register.
REQ-013 outIFIDInstr  output  32  IF/ID instruction register.
REQ-014 outIFIDPCPlus4  output  32  IF/ID PC+4 register.
REQ-015 outIFIDValid  output  1  IF/ID holds a real instruction.

Function
REQ-016 FSM states: BOOT, REQ, HOLD, DRAIN; encoding in package.
REQ-017 BOOT: outImemReq=0; next cycle -> REQ unconditionally.
REQ-018 REQ: outImemReq=1, outImemAddr=PC; once asserted, req and addr stay stable until inImemReady=1.
REQ-019 REQ, inImemReady=1, inPCSrc=0, inStall=0: IF/ID <= {inImemData, PC+4, valid=1}; PC <= PC+4; stay REQ.
REQ-020 REQ, inImemReady=1, inPCSrc=0, inStall=1: word and PC+4 captured in skid buffer; IF/ID and PC hold; -> HOLD.
REQ-021 HOLD: outImemReq=0; when inStall=0, IF/ID <= skid contents, PC <= PC+4, -> REQ.
REQ-022 inPCSrc=1 has priority over inStall in every state.
REQ-023 REQ, inPCSrc=1, inImemReady=1: returned word discarded; PC <= inBranchTarget; IF/ID flushed (valid=0, instr=NOP_WORD); stay REQ.
REQ-024 REQ, inPCSrc=1, inImemReady=0: target latched in redirect register; IF/ID flushed; -> DRAIN.
REQ-025 DRAIN: outImemReq=1 at old address; on inImemReady=1 word discarded, PC <= latched target, -> REQ; further inPCSrc=1 in DRAIN overwrites latched target.
REQ-026 HOLD, inPCSrc=1: skid buffer discarded; PC <= inBranchTarget; IF/ID flushed; -> REQ.
REQ-027 PC+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0); no overflow flag.
REQ-028 inBranchTarget used as given; no alignment check.
REQ-029 inStall=1 without pending data (REQ, inImemReady=0): no state change besides continued request.
REQ-030 Fetch latency: one cycle from inImemReady to outIFIDValid=1 with no stall.

Reset
REQ-031 On rst_n=0: PC=PC_RESET, state=BOOT, outIFIDValid=0, outIFIDInstr=NOP_WORD, outIFIDPCPlus4=0, skid and redirect registers 0, outImemReq=0.
REQ-032 Reset mid-request abandons the transaction; memory ignores a later inImemReady only by its own reset.

Structure
REQ-033 Shared package holds state typedef, NOP_WORD default, PC step constant (4).
REQ-034 One sub-module natural: if_id_reg (valid/instr/PC+4 register with load, hold, flush).

Verification
REQ-035 Reset release, ready every cycle -> addresses 0,4,8; outIFIDPCPlus4 = 4,8,12 one cycle after each ready.
REQ-036 Ready with inStall=1 at PC=8 -> HOLD, IF/ID unchanged; inStall drops -> IF/ID instr=word@8, PC=12.
REQ-037 inPCSrc=1, target=0x40, same cycle as ready at PC=0x10 -> word dropped, outIFIDValid=0, next outImemAddr=0x40.
REQ-038 inPCSrc=1, target=0x80 with memory 3-cycle latency -> addr 0x14 held until ready, word dropped, then addr 0x80.
REQ-039 inPCSrc=1 and inStall=1 same cycle in HOLD -> flush, PC=target, skid discarded.
REQ-040 PC=32'hFFFF_FFFC fetch completes -> PC=0, outIFIDPCPlus4=0.
